qdr_multiport_arbiter: RTL

//  Parametrised successor to the single-master QDR sniffer. Shares one QDR controller user

---
 rtl/qdr_multiport_arbiter_if.sv | 39 +++
 rtl/qdr_multiport_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/qdr_multiport_arbiter_if.sv
// Requester-port and QDR-controller user-port bundle for qdr_multiport_arbiter.
// Modport master is the arbiter's view; modport slave is the surrounding environment's view.
interface qdr_multiport_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 22,
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned BE_WIDTH   = 4
);
  logic [NUM_PORTS*ADDR_WIDTH-1:0] slave_addr;
  logic [NUM_PORTS-1:0]            slave_wr_strb;
  logic [NUM_PORTS*DATA_WIDTH-1:0] slave_wr_data;
  logic [NUM_PORTS*BE_WIDTH-1:0]   slave_wr_be;
  logic [NUM_PORTS-1:0]            slave_rd_strb;
  logic [NUM_PORTS-1:0]            slave_ack;
  logic [NUM_PORTS*DATA_WIDTH-1:0] slave_rd_data;
  logic [NUM_PORTS-1:0]            slave_rd_dvld;

  logic [ADDR_WIDTH-1:0]           master_addr;
  logic                            master_wr_strb;
  logic [DATA_WIDTH-1:0]           master_wr_data;
  logic [BE_WIDTH-1:0]             master_wr_be;
  logic                            master_rd_strb;
  logic [DATA_WIDTH-1:0]           master_rd_data;
  logic                            master_rd_dvld;

  modport master (
    input  slave_addr, slave_wr_strb, slave_wr_data, slave_wr_be, slave_rd_strb,
    input  master_rd_data, master_rd_dvld,
    output slave_ack, slave_rd_data, slave_rd_dvld,
    output master_addr, master_wr_strb, master_wr_data, master_wr_be, master_rd_strb
  );

  modport slave (
    output slave_addr, slave_wr_strb, slave_wr_data, slave_wr_be, slave_rd_strb,
    output master_rd_data, master_rd_dvld,
    input  slave_ack, slave_rd_data, slave_rd_dvld,
    input  master_addr, master_wr_strb, master_wr_data, master_wr_be, master_rd_strb
  );
endinterface

// File: rtl/qdr_multiport_arbiter.sv
// Shares one QDR controller user port among NUM_PORTS requesters; a read-tag FIFO routes
// each returning read word back to the port that issued it.
module qdr_multiport_arbiter #(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned ADDR_WIDTH   = 22,
  parameter int unsigned DATA_WIDTH   = 36,
  parameter int unsigned BE_WIDTH     = 4,
  parameter int unsigned RD_TAG_DEPTH = 16,
  parameter bit          PRIO_EN      = 1'b1
) (
  input  logic                          qdr_clk,
  input  logic                          qdr_rst,
  qdr_multiport_arbiter_if.master       bus,
  input  logic                          phy_rdy,
  input  logic                          cal_fail,
  output logic [$clog2(RD_TAG_DEPTH):0] rd_outstanding,
  output logic                          rd_underflow
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned TW = $clog2(RD_TAG_DEPTH);
  localparam int unsigned CW = TW + 1;

  logic [NUM_PORTS-1:0]            elig;
  logic                            fifo_full;
  logic                            grant_vld, grant_rr;
  logic [PW-1:0]                   grant_idx;
  logic [PW-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]           g_addr;
  logic [DATA_WIDTH-1:0]           g_data;
  logic [BE_WIDTH-1:0]             g_be;
  logic                            g_wr, g_rd;
  logic                            push, pop, underflow_evt;
  logic [PW-1:0]                   tag_out;

  logic [NUM_PORTS-1:0]            ack_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_PORTS-1:0]            rd_dvld_q;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic                            wr_strb_q, rd_strb_q;
  logic [DATA_WIDTH-1:0]           wr_data_q;
  logic [BE_WIDTH-1:0]             wr_be_q;
  logic [TW-1:0]                   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                   count_q;
  logic                            underflow_q;
  logic [PW-1:0]                   tag_mem_q [RD_TAG_DEPTH];

  assign fifo_full = (count_q == CW'(RD_TAG_DEPTH));

  // A port whose ack is high this cycle still holds its strobes; masking it avoids a double grant.
  always_comb begin
    elig = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      elig[p] = (bus.slave_wr_strb[p] | bus.slave_rd_strb[p]) & ~ack_q[p]
              & (~bus.slave_rd_strb[p] | ~fifo_full) & phy_rdy & ~cal_fail;
    end
  end

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_rr  = 1'b0;
    grant_idx = '0;
    if (PRIO_EN && elig[0]) begin
      grant_vld = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = (32'(rr_ptr_q) + k) % NUM_PORTS;
        if (!grant_vld && elig[idx[PW-1:0]]) begin
          grant_vld = 1'b1;
          grant_rr  = 1'b1;
          grant_idx = idx[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_rr) begin
      rr_ptr_d = (32'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + PW'(1);
    end
  end

  always_comb begin
    g_addr = bus.slave_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    g_data = bus.slave_wr_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    g_be   = bus.slave_wr_be[32'(grant_idx)*BE_WIDTH +: BE_WIDTH];
    g_wr   = bus.slave_wr_strb[grant_idx];
    g_rd   = bus.slave_rd_strb[grant_idx];
  end

  assign push          = grant_vld & g_rd;
  assign pop           = bus.master_rd_dvld & (count_q != '0);
  assign underflow_evt = bus.master_rd_dvld & (count_q == '0);
  assign tag_out       = tag_mem_q[rd_ptr_q];

  always_ff @(posedge qdr_clk) begin
    if (qdr_rst) begin
      ack_q       <= '0;
      rd_data_q   <= '0;
      rd_dvld_q   <= '0;
      addr_q      <= '0;
      wr_strb_q   <= 1'b0;
      rd_strb_q   <= 1'b0;
      wr_data_q   <= '0;
      wr_be_q     <= '0;
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      ack_q     <= '0;
      wr_strb_q <= 1'b0;
      rd_strb_q <= 1'b0;
      rd_dvld_q <= '0;
      rr_ptr_q  <= rr_ptr_d;
      if (grant_vld) begin
        ack_q[grant_idx] <= 1'b1;
        addr_q           <= g_addr;
        wr_strb_q        <= g_wr;
        rd_strb_q        <= g_rd;
        // Write data/BE only move on a write so a read-only grant leaves them as they were.
        if (g_wr) begin
          wr_data_q <= g_data;
          wr_be_q   <= g_be;
        end
      end
      if (pop) begin
        rd_dvld_q[tag_out]                              <= 1'b1;
        rd_data_q[32'(tag_out)*DATA_WIDTH +: DATA_WIDTH] <= bus.master_rd_data;
      end
      wr_ptr_q <= wr_ptr_q + TW'(push);
      rd_ptr_q <= rd_ptr_q + TW'(pop);
      count_q  <= count_q + CW'(push) - CW'(pop);
      if (underflow_evt) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge qdr_clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign bus.slave_ack      = ack_q;
  assign bus.slave_rd_data  = rd_data_q;
  assign bus.slave_rd_dvld  = rd_dvld_q;
  assign bus.master_addr    = addr_q;
  assign bus.master_wr_strb = wr_strb_q;
  assign bus.master_rd_strb = rd_strb_q;
  assign bus.master_wr_data = wr_data_q;
  assign bus.master_wr_be   = wr_be_q;
  assign rd_outstanding     = count_q;
  assign rd_underflow       = underflow_q;

endmodule
